mcycle_ctrl: RTL and testbench
==============================

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 instruction  input  32  instruction word from datapath IR; valid from ID state onward.
REQ-004 mem_ready  input  1  memory handshake; 1 = current IM fetch / DM access completes this cycle.
REQ-005 ALUctr  output  4  ALU op: 0000 ADDU, 0001 SUBU, 0010 AND, 0011 OR, 0100 SLT, 0101 LUI-pass.
REQ-006 ExtOp  output  2  00 zero-extend, 01 sign-extend, 10 upper (imm16<<16).
REQ-007 ALUsrc, RegDst, jump, Branch, MemtoReg  output  1 each  datapath mux/NPC selects.
REQ-008 MemWr, RegWr  output  1 each  DM write strobe, register-file write strobe.
REQ-009 PCWr, IRWr  output  1 each  PC update enable, instruction-register load enable.
REQ-010 state  output  3  current state code, for debug and verification.
REQ-011 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-012 States SHALL be IF=000, ID=001, EX=010, MEM=011, WB=100, ERR=111; other codes unreachable, and any such code SHALL transition to IF.
REQ-013 IF: IRWr=PCWr=mem_ready; stay in IF while mem_ready=0; go to ID on mem_ready=1.
REQ-014 ID: latch opcode instruction[31:26] and funct instruction[5:0] into internal registers; all later decode SHALL use the latched copy only.
REQ-015 Supported: R-type op 000000 with funct 100001 addu, 100011 subu, 100100 and, 100101 or, 101010 slt; ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010.
REQ-016 ID -> IF for j, asserting jump=1 and PCWr=1 for that one cycle; ID -> EX for all other supported opcodes.
REQ-017 EX: R-type ALUsrc=0, ALUctr per funct; ori ALUsrc=1, ExtOp=00, ALUctr=OR; lui ALUsrc=1, ExtOp=10, ALUctr=LUI-pass; lw/sw ALUsrc=1, ExtOp=01, ALUctr=ADDU.
REQ-018 EX beq: ALUsrc=0, ALUctr=SUBU, ExtOp=01, Branch=1, PCWr=1 for one cycle, next IF; NPC uses ALU zero.
REQ-019 EX -> MEM for lw/sw; EX -> WB for R-type/ori/lui.
REQ-020 MEM: EX ALU/ext selects held; sw MemWr=mem_ready, -> IF on mem_ready; lw -> WB on mem_ready; hold while mem_ready=0.
REQ-021 WB: RegWr=1 for exactly one cycle; RegDst=1 for R-type else 0; MemtoReg=1 for lw else 0; next IF.
REQ-022 Outputs SHALL be Moore functions of state and latched opcode/funct; outputs not listed for a state SHALL be 0.
REQ-023 RegWr, MemWr, PCWr, IRWr SHALL never be 1 for more than one cycle per instruction.
REQ-024 Latency with mem_ready tied 1: j 2, beq 3, R-type/ori/lui 4, sw 4, lw 5 cycles; each mem_ready=0 cycle in IF/MEM adds one.
REQ-025 Unsupported funct under op 000000 SHALL be handled as an illegal opcode.

Reset
REQ-026 On rst=1 at a clock edge: state=IF, latched opcode/funct=0, illegal=0, all strobes 0, from any state including mid-instruction (no partial RegWr/MemWr after reset).
REQ-027 rst SHALL take priority over mem_ready and all transitions.

Configuration
REQ-028 Macro MCTRL_ILLEGAL_DET_EN defined: illegal opcode in ID -> ERR, illegal=1; ERR holds with all strobes 0 until rst.
REQ-029 Macro undefined: illegal opcode in ID -> IF with no strobes asserted (NOP, 2 cycles); illegal tied 0.

Verification
REQ-030 addu $3,$1,$2 (0x00221821), mem_ready=1 -> states IF,ID,EX,WB; RegWr=1 only in WB with RegDst=1, ALUctr=0000.
REQ-031 lw (0x8C220004), mem_ready=0 for 2 cycles in MEM -> MEM held 3 cycles, MemWr=0 throughout, WB with MemtoReg=1, 7 cycles total.
REQ-032 beq (0x10220003) -> IF,ID,EX; Branch=1, PCWr=1, ALUctr=0001 in EX only; 3 cycles.
REQ-033 j (0x08000010) -> PCWr=1 and jump=1 in ID, return to IF; 2 cycles.
REQ-034 rst=1 during MEM of sw 0xAC220008 -> next state IF, MemWr never asserted.
REQ-035 opcode 0x3F: with MCTRL_ILLEGAL_DET_EN -> state=111, illegal=1 until rst; without -> back to IF, illegal=0.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle control FSM for a MIPS subset (IF/ID/EX/MEM/WB, plus ERR trap).
// Optional feature: define MCTRL_ILLEGAL_DET_EN to trap illegal opcodes in a sticky ERR state.
module mcycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic [3:0]  ALUctr,
  output logic [1:0]  ExtOp,
  output logic        ALUsrc,
  output logic        RegDst,
  output logic        jump,
  output logic        Branch,
  output logic        MemtoReg,
  output logic        MemWr,
  output logic        RegWr,
  output logic        PCWr,
  output logic        IRWr,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100,
    S_ERR = 3'b111
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  state_e     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [5:0] funct_q, funct_d;
  logic [5:0] liveOp, liveFn;
  logic       liveLegal;
  logic       unused_instr_bits;

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: isLegal = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
                          (fn == FN_OR) || (fn == FN_SLT);
      OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: isLegal = 1'b1;
      default:  isLegal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rtypeAlu(input logic [5:0] fn);
    case (fn)
      FN_SUBU: rtypeAlu = ALU_SUBU;
      FN_AND:  rtypeAlu = ALU_AND;
      FN_OR:   rtypeAlu = ALU_OR;
      FN_SLT:  rtypeAlu = ALU_SLT;
      default: rtypeAlu = ALU_ADDU;
    endcase
  endfunction

  // ID decides from the live IR word; EX onwards only looks at the latched copy.
  assign liveOp            = instruction[31:26];
  assign liveFn            = instruction[5:0];
  assign liveLegal         = isLegal(liveOp, liveFn);
  assign unused_instr_bits = ^instruction[25:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

`ifdef MCTRL_ILLEGAL_DET_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_ID && !liveLegal) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = S_IF;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      S_IF: state_d = mem_ready ? S_ID : S_IF;
      S_ID: begin
        opcode_d = liveOp;
        funct_d  = liveFn;
        if (!liveLegal) begin
`ifdef MCTRL_ILLEGAL_DET_EN
          state_d = S_ERR;
`else
          state_d = S_IF;
`endif
        end else if (liveOp == OP_J) begin
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (opcode_q == OP_LW || opcode_q == OP_SW) state_d = S_MEM;
        else if (opcode_q == OP_BEQ)                state_d = S_IF;
        else                                        state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_ready)              state_d = S_MEM;
        else if (opcode_q == OP_LW)  state_d = S_WB;
        else                         state_d = S_IF;
      end
      S_WB:    state_d = S_IF;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IF;
    endcase
  end

  // Write strobes are forced low while rst is high so a reset never leaves a partial write.
  always_comb begin
    ALUctr   = ALU_ADDU;
    ExtOp    = EXT_ZERO;
    ALUsrc   = 1'b0;
    RegDst   = 1'b0;
    jump     = 1'b0;
    Branch   = 1'b0;
    MemtoReg = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    case (state_q)
      S_IF: begin
        IRWr = mem_ready;
        PCWr = mem_ready;
      end
      S_ID: begin
        if (liveOp == OP_J) begin
          jump = 1'b1;
          PCWr = 1'b1;
        end
      end
      S_EX: begin
        case (opcode_q)
          OP_RTYPE: ALUctr = rtypeAlu(funct_q);
          OP_ORI: begin
            ALUsrc = 1'b1;
            ExtOp  = EXT_ZERO;
            ALUctr = ALU_OR;
          end
          OP_LUI: begin
            ALUsrc = 1'b1;
            ExtOp  = EXT_UPPER;
            ALUctr = ALU_LUI;
          end
          OP_LW, OP_SW: begin
            ALUsrc = 1'b1;
            ExtOp  = EXT_SIGN;
            ALUctr = ALU_ADDU;
          end
          OP_BEQ: begin
            ExtOp  = EXT_SIGN;
            ALUctr = ALU_SUBU;
            Branch = 1'b1;
            PCWr   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUsrc = 1'b1;
        ExtOp  = EXT_SIGN;
        ALUctr = ALU_ADDU;
        MemWr  = (opcode_q == OP_SW) && mem_ready;
      end
      S_WB: begin
        RegWr    = 1'b1;
        RegDst   = (opcode_q == OP_RTYPE);
        MemtoReg = (opcode_q == OP_LW);
      end
      default: ;
    endcase
    if (rst) begin
      MemWr = 1'b0;
      RegWr = 1'b0;
      PCWr  = 1'b0;
      IRWr  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: table-driven, hand-written and randomized checks of mcycle_ctrl against an
// instruction-level model (each instruction is a string of phase letters F/D/X/M/W/E).
module tb_mcycle_ctrl;

  typedef struct packed {
    logic [3:0] aluCtr;
    logic [1:0] extOp;
    logic       aluSrc;
    logic       regDst;
    logic       jump;
    logic       branch;
    logic       memToReg;
    logic       memWr;
    logic       regWr;
    logic       pcWr;
    logic       irWr;
    logic [2:0] st;
    logic       ill;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    int          latency;
    logic [3:0]  alu;
    logic [1:0]  ext;
    logic        src;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        mem_ready;
  logic [3:0]  ALUctr;
  logic [1:0]  ExtOp;
  logic        ALUsrc, RegDst, jump, Branch, MemtoReg;
  logic        MemWr, RegWr, PCWr, IRWr;
  logic [2:0]  state;
  logic        illegal;
  outs_t       act;

  int checks = 0;
  int passed = 0;

  logic [5:0] rFn [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};
  vec_t       vecs [11];

  mcycle_ctrl dut (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .ALUctr(ALUctr), .ExtOp(ExtOp), .ALUsrc(ALUsrc), .RegDst(RegDst), .jump(jump),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWr(MemWr), .RegWr(RegWr), .PCWr(PCWr),
    .IRWr(IRWr), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {ALUctr, ExtOp, ALUsrc, RegDst, jump, Branch, MemtoReg,
                MemWr, RegWr, PCWr, IRWr, state, illegal};

  // Instruction-level model: the sequence of phases an instruction walks through.
  function automatic string phasesFor(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: begin
        if (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a)
          return "FDXW";
      end
      6'h0d, 6'h0f: return "FDXW";
      6'h23:        return "FDXMW";
      6'h2b:        return "FDXM";
      6'h04:        return "FDX";
      6'h02:        return "FD";
      default: ;
    endcase
`ifdef MCTRL_ILLEGAL_DET_EN
    return "FDE";
`else
    return "FD";
`endif
  endfunction

  function automatic logic [3:0] rAlu(input logic [5:0] fn);
    case (fn)
      6'h21:   return 4'b0000;
      6'h23:   return 4'b0001;
      6'h24:   return 4'b0010;
      6'h25:   return 4'b0011;
      6'h2a:   return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic outs_t expectFor(input byte ph, input logic [31:0] ins,
                                      input logic mr, input logic rstIn);
    outs_t      e;
    logic [5:0] op;
    e  = '0;
    op = ins[31:26];
    case (ph)
      "F": begin e.st = 3'd0; e.irWr = mr; e.pcWr = mr; end
      "D": begin
        e.st = 3'd1;
        if (op == 6'h02) begin e.jump = 1'b1; e.pcWr = 1'b1; end
      end
      "X": begin
        e.st = 3'd2;
        case (op)
          6'h00: e.aluCtr = rAlu(ins[5:0]);
          6'h0d: begin e.aluSrc = 1'b1; e.extOp = 2'b00; e.aluCtr = 4'b0011; end
          6'h0f: begin e.aluSrc = 1'b1; e.extOp = 2'b10; e.aluCtr = 4'b0101; end
          6'h23, 6'h2b: begin e.aluSrc = 1'b1; e.extOp = 2'b01; e.aluCtr = 4'b0000; end
          6'h04: begin
            e.extOp = 2'b01; e.aluCtr = 4'b0001; e.branch = 1'b1; e.pcWr = 1'b1;
          end
          default: ;
        endcase
      end
      "M": begin
        e.st = 3'd3; e.aluSrc = 1'b1; e.extOp = 2'b01; e.aluCtr = 4'b0000;
        e.memWr = (op == 6'h2b) && mr;
      end
      "W": begin
        e.st = 3'd4; e.regWr = 1'b1;
        e.regDst = (op == 6'h00); e.memToReg = (op == 6'h23);
      end
      "E": begin e.st = 3'd7; e.ill = 1'b1; end
      default: ;
    endcase
    if (rstIn) begin
      e.memWr = 1'b0; e.regWr = 1'b0; e.pcWr = 1'b0; e.irWr = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Runs one instruction from its fetch to its last phase, checking every cycle.
  task automatic applyStimulus(input string name, input logic [31:0] ins, input bit randMr,
                               input int fStalls, input int mStalls,
                               output int cycles, output outs_t exAct, output int memCycles);
    string ph;
    int    idx, fCnt, mCnt, eCnt;
    byte   p;
    logic  mr, r;
    ph = phasesFor(ins);
    idx = 0; fCnt = 0; mCnt = 0; eCnt = 0;
    cycles = 0; memCycles = 0; exAct = '0;
    while (idx < ph.len()) begin
      p = ph[idx];
      if (randMr)        mr = ($urandom_range(0, 3) != 0);
      else if (p == "F") mr = (fCnt >= fStalls);
      else if (p == "M") mr = (mCnt >= mStalls);
      else               mr = 1'($urandom_range(0, 1));
      r = (p == "E") && (eCnt == 2);
      @(negedge clk);
      instruction = ins;
      mem_ready   = mr;
      rst         = r;
      #1;
      checkOutput({name, " cycle"}, int'(act), int'(expectFor(p, ins, mr, r)));
      cycles++;
      if (p == "X") exAct = act;
      if (p == "M") memCycles++;
      if (p == "E") begin
        eCnt++;
        if (r) idx = ph.len();
      end else if ((p == "F" || p == "M") && !mr) begin
        if (p == "F") fCnt++;
        else          mCnt++;
      end else begin
        idx++;
      end
      if (cycles > 200) begin
        checkOutput({name, " cycle budget"}, cycles, 200);
        idx = ph.len();
      end
    end
  endtask

  initial begin
    int          cyc, memCyc;
    outs_t       ex;
    logic [31:0] ins, base;

    vecs[0]  = '{"addu", 32'h00221821, 4, 4'b0000, 2'b00, 1'b0};
    vecs[1]  = '{"subu", 32'h00221823, 4, 4'b0001, 2'b00, 1'b0};
    vecs[2]  = '{"and",  32'h00221824, 4, 4'b0010, 2'b00, 1'b0};
    vecs[3]  = '{"or",   32'h00221825, 4, 4'b0011, 2'b00, 1'b0};
    vecs[4]  = '{"slt",  32'h0022182a, 4, 4'b0100, 2'b00, 1'b0};
    vecs[5]  = '{"ori",  32'h34220005, 4, 4'b0011, 2'b00, 1'b1};
    vecs[6]  = '{"lui",  32'h3c011234, 4, 4'b0101, 2'b10, 1'b1};
    vecs[7]  = '{"lw",   32'h8c220004, 5, 4'b0000, 2'b01, 1'b1};
    vecs[8]  = '{"sw",   32'hac220008, 4, 4'b0000, 2'b01, 1'b1};
    vecs[9]  = '{"beq",  32'h10220003, 3, 4'b0001, 2'b01, 1'b0};
    vecs[10] = '{"j",    32'h08000010, 2, 4'b0000, 2'b00, 1'b0};

    rst = 1'b1; mem_ready = 1'b1; instruction = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset state", int'(act), int'(expectFor("F", 32'h0, 1'b1, 1'b1)));

    // Table-driven: mem_ready tied high, check latency and EX selects.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].ins, 1'b0, 0, 0, cyc, ex, memCyc);
      checkOutput({vecs[i].name, " latency"}, cyc, vecs[i].latency);
      checkOutput({vecs[i].name, " EX selects"}, {ex.aluCtr, ex.extOp, ex.aluSrc},
                  {vecs[i].alu, vecs[i].ext, vecs[i].src});
    end

    // lw with two memory wait cycles.
    applyStimulus("lw stall", 32'h8c220004, 1'b0, 0, 2, cyc, ex, memCyc);
    checkOutput("lw stall latency", cyc, 7);
    checkOutput("lw stall MEM cycles", memCyc, 3);

    // addu with three fetch wait cycles.
    applyStimulus("addu fetch stall", 32'h00221821, 1'b0, 3, 0, cyc, ex, memCyc);
    checkOutput("addu fetch stall latency", cyc, 7);

    // Reset asserted during the MEM phase of sw while memory reports ready.
    ins = 32'hac220008;
    @(negedge clk); instruction = ins; mem_ready = 1'b1; rst = 1'b0;
    #1 checkOutput("sw rst IF", int'(act), int'(expectFor("F", ins, 1'b1, 1'b0)));
    @(negedge clk);
    #1 checkOutput("sw rst ID", int'(act), int'(expectFor("D", ins, 1'b1, 1'b0)));
    @(negedge clk);
    #1 checkOutput("sw rst EX", int'(act), int'(expectFor("X", ins, 1'b1, 1'b0)));
    @(negedge clk); rst = 1'b1;
    #1 checkOutput("sw rst MEM", int'(act), int'(expectFor("M", ins, 1'b1, 1'b1)));
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0;
    #1 checkOutput("sw rst after", int'(act), int'(expectFor("F", ins, 1'b0, 1'b0)));

    // Illegal opcode 0x3F and an unsupported R-type funct.
    applyStimulus("illegal op3F", 32'hfc000000, 1'b0, 0, 0, cyc, ex, memCyc);
`ifdef MCTRL_ILLEGAL_DET_EN
    checkOutput("illegal op3F cycles", cyc, 5);
`else
    checkOutput("illegal op3F cycles", cyc, 2);
`endif
    applyStimulus("illegal funct", 32'h00221800, 1'b0, 0, 0, cyc, ex, memCyc);
    applyStimulus("addu after illegal", 32'h00221821, 1'b0, 0, 0, cyc, ex, memCyc);
    checkOutput("addu after illegal latency", cyc, 4);

    // Randomized instruction stream with random memory handshakes.
    for (int n = 0; n < 300; n++) begin
      base = $urandom();
      case ($urandom_range(0, 9))
        0, 1: ins = {6'h00, base[25:6], rFn[$urandom_range(0, 4)]};
        2: ins = {6'h0d, base[25:0]};
        3: ins = {6'h0f, base[25:0]};
        4: ins = {6'h23, base[25:0]};
        5: ins = {6'h2b, base[25:0]};
        6: ins = {6'h04, base[25:0]};
        7: ins = {6'h02, base[25:0]};
        default: ins = $urandom();
      endcase
      applyStimulus("random", ins, 1'b1, 0, 0, cyc, ex, memCyc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
